seq_loop_status_tracker: RTL and testbench

Synthesizable run-time status tracker for an HLS-style accelerator core. It watches the core's block-level handshake (ap_start/ap_ready/ap_done/ap_continue) and its one-hot FSM state. From these it reports transaction counts and latencies, plus loop entry/exit, trip counts and per-iteration latency for one sequential loop. It sits beside the kernel top level as a passive observer and never drives the kernel.

---
 rtl/seq_loop_status_tracker_if.sv | 27 ++
 rtl/seq_loop_status_tracker.sv | 133 +++++++++++++
 tb/tb_seq_loop_status_tracker.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_loop_status_tracker_if.sv
// Block-level handshake and FSM state of an HLS kernel, as seen by a passive observer.
// The kernel (or a bench) drives through master; the tracker only listens through slave.
interface seq_loop_status_tracker_if #(
    parameter int STATE_W = 4
);
    logic               ap_start;
    logic               ap_ready;
    logic               ap_done;
    logic               ap_continue;
    logic [STATE_W-1:0] cur_state;

    modport master (
        output ap_start,
        output ap_ready,
        output ap_done,
        output ap_continue,
        output cur_state
    );

    modport slave (
        input ap_start,
        input ap_ready,
        input ap_done,
        input ap_continue,
        input cur_state
    );
endinterface

// File: rtl/seq_loop_status_tracker.sv
// Passive run-time statistics for an HLS kernel: transaction counts and latencies,
// plus entry/exit, trip count and per-iteration latency of one sequential loop.
module seq_loop_status_tracker #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    seq_loop_status_tracker_if.slave kernel,
    input  logic                 finish,
    input  logic [STATE_W-1:0]   pre_loop_state,
    input  logic [STATE_W-1:0]   post_loop_state,
    input  logic [STATE_W-1:0]   quit_loop_state,
    input  logic [STATE_W-1:0]   iter_start_state,
    input  logic [STATE_W-1:0]   iter_end_state,
    input  logic                 pre_states_valid,
    input  logic                 post_states_valid,
    input  logic                 quit_states_valid,
    input  logic                 iter_end_states_valid,
    input  logic                 one_state_loop,
    output logic                 busy,
    output logic [CNT_W-1:0]     start_count,
    output logic [CNT_W-1:0]     done_count,
    output logic [CNT_W-1:0]     ready_count,
    output logic [CNT_W-1:0]     last_module_latency,
    output logic                 loop_active,
    output logic [CNT_W-1:0]     loop_exec_count,
    output logic [CNT_W-1:0]     iter_count,
    output logic [CNT_W-1:0]     last_trip_count,
    output logic [CNT_W-1:0]     last_iter_latency,
    output logic                 frozen
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [STATE_W-1:0] prev_state;
    logic [CNT_W-1:0]   mod_cnt;
    logic [CNT_W-1:0]   iter_cnt;

    logic               accept;
    logic               complete;
    logic [CNT_W-1:0]   mod_now;
    logic               at_iter_start;
    logic               entry;
    logic               loop_exit;
    logic               in_loop;
    logic               iter_begin;
    logic               iter_done;
    logic [CNT_W-1:0]   iter_now;
    logic [CNT_W-1:0]   iter_count_nxt;
    logic               hold;

    // mod_now / iter_now are the cycle counts including the current cycle,
    // so an event in this cycle captures an inclusive latency.
    always_comb begin
        accept         = kernel.ap_start & ~busy;
        complete       = kernel.ap_done & kernel.ap_continue & (busy | accept);
        mod_now        = accept ? CNT_ONE : mod_cnt + CNT_ONE;

        at_iter_start  = (kernel.cur_state == iter_start_state);
        entry          = ~loop_active & pre_states_valid
                         & (prev_state == pre_loop_state) & at_iter_start;
        loop_exit      = loop_active & quit_states_valid & (prev_state == quit_loop_state)
                         & post_states_valid & (kernel.cur_state == post_loop_state);
        in_loop        = loop_active | entry;
        iter_begin     = at_iter_start
                         & (entry | (prev_state != iter_start_state) | one_state_loop);
        iter_now       = iter_begin ? CNT_ONE : iter_cnt + CNT_ONE;

        iter_done      = 1'b0;
        if (in_loop) begin
            if (one_state_loop)
                iter_done = at_iter_start;
            else
                iter_done = iter_end_states_valid & (kernel.cur_state == iter_end_state)
                            & (prev_state != iter_end_state);
        end

        // an iteration that ends on the exit cycle still belongs to the trip count
        iter_count_nxt = (entry ? '0 : iter_count) + (iter_done ? CNT_ONE : '0);
        hold           = frozen | finish;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_state          <= '0;
            mod_cnt             <= '0;
            iter_cnt            <= '0;
            busy                <= 1'b0;
            start_count         <= '0;
            done_count          <= '0;
            ready_count         <= '0;
            last_module_latency <= '0;
            loop_active         <= 1'b0;
            loop_exec_count     <= '0;
            iter_count          <= '0;
            last_trip_count     <= '0;
            last_iter_latency   <= '0;
            frozen              <= 1'b0;
        end else begin
            prev_state <= kernel.cur_state;
            frozen     <= hold;
            if (!hold) begin
                if (accept)
                    start_count <= start_count + CNT_ONE;
                if (accept | busy)
                    mod_cnt <= mod_now;
                if (complete) begin
                    done_count          <= done_count + CNT_ONE;
                    last_module_latency <= mod_now;
                    busy                <= 1'b0;
                end else if (accept) begin
                    busy <= 1'b1;
                end
                if (kernel.ap_ready)
                    ready_count <= ready_count + CNT_ONE;

                if (in_loop | iter_begin)
                    iter_cnt <= iter_now;
                if (entry)
                    loop_exec_count <= loop_exec_count + CNT_ONE;
                iter_count <= iter_count_nxt;
                if (iter_done)
                    last_iter_latency <= iter_now;
                if (loop_exit) begin
                    loop_active     <= 1'b0;
                    last_trip_count <= iter_count_nxt;
                end else if (entry) begin
                    loop_active <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_loop_status_tracker.sv
// Directed test-plan scenarios plus randomized traffic against a timestamp-based
// reference model of the tracker.
module tb_seq_loop_status_tracker;
    localparam int STATE_W = 4;
    localparam int CNT_W   = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;

    seq_loop_status_tracker_if #(.STATE_W(STATE_W)) kif ();

    logic               finish;
    logic [STATE_W-1:0] pre_loop_state, post_loop_state, quit_loop_state;
    logic [STATE_W-1:0] iter_start_state, iter_end_state;
    logic               pre_states_valid, post_states_valid, quit_states_valid;
    logic               iter_end_states_valid, one_state_loop;

    logic               busy, loop_active, frozen;
    logic [CNT_W-1:0]   start_count, done_count, ready_count, last_module_latency;
    logic [CNT_W-1:0]   loop_exec_count, iter_count, last_trip_count, last_iter_latency;

    seq_loop_status_tracker #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .kernel                (kif),
        .finish                (finish),
        .pre_loop_state        (pre_loop_state),
        .post_loop_state       (post_loop_state),
        .quit_loop_state       (quit_loop_state),
        .iter_start_state      (iter_start_state),
        .iter_end_state        (iter_end_state),
        .pre_states_valid      (pre_states_valid),
        .post_states_valid     (post_states_valid),
        .quit_states_valid     (quit_states_valid),
        .iter_end_states_valid (iter_end_states_valid),
        .one_state_loop        (one_state_loop),
        .busy                  (busy),
        .start_count           (start_count),
        .done_count            (done_count),
        .ready_count           (ready_count),
        .last_module_latency   (last_module_latency),
        .loop_active           (loop_active),
        .loop_exec_count       (loop_exec_count),
        .iter_count            (iter_count),
        .last_trip_count       (last_trip_count),
        .last_iter_latency     (last_iter_latency),
        .frozen                (frozen)
    );

    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Reference model: latencies come from start timestamps, not running counters.
    logic               m_busy, m_active, m_frozen;
    logic [CNT_W-1:0]   m_starts, m_dones, m_readys, m_mod_lat;
    logic [CNT_W-1:0]   m_execs, m_iters, m_trip, m_iter_lat;
    logic [STATE_W-1:0] m_prev;
    int                 m_t0, m_it0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic modelReset();
        m_busy = 0; m_active = 0; m_frozen = 0; m_prev = '0;
        m_starts = 0; m_dones = 0; m_readys = 0; m_mod_lat = 0;
        m_execs = 0; m_iters = 0; m_trip = 0; m_iter_lat = 0;
        m_t0 = 0; m_it0 = 0;
    endtask

    task automatic modelStep();
        logic acc, entering, leaving, in_loop, ended;
        logic [STATE_W-1:0] cs;
        cs = kif.cur_state;
        if (m_frozen || finish) begin
            m_frozen = 1;
            m_prev   = cs;
            return;
        end
        acc = kif.ap_start && !m_busy;
        if (acc) begin
            m_starts++;
            m_t0 = cyc;
        end
        if (kif.ap_done && kif.ap_continue && (m_busy || acc)) begin
            m_dones++;
            m_mod_lat = 32'(cyc - m_t0 + 1);
            m_busy    = 0;
        end else if (acc) begin
            m_busy = 1;
        end
        if (kif.ap_ready) m_readys++;

        entering = !m_active && pre_states_valid && m_prev == pre_loop_state
                   && cs == iter_start_state;
        leaving  = m_active && quit_states_valid && m_prev == quit_loop_state
                   && post_states_valid && cs == post_loop_state;
        in_loop  = m_active || entering;
        if (entering) begin
            m_execs++;
            m_iters = 0;
        end
        if (cs == iter_start_state && (entering || m_prev != iter_start_state || one_state_loop))
            m_it0 = cyc;
        if (one_state_loop)
            ended = in_loop && cs == iter_start_state;
        else
            ended = in_loop && iter_end_states_valid && cs == iter_end_state
                    && m_prev != iter_end_state;
        if (ended) begin
            m_iters++;
            m_iter_lat = 32'(cyc - m_it0 + 1);
        end
        if (leaving) begin
            m_trip   = m_iters;
            m_active = 0;
        end else if (entering) begin
            m_active = 1;
        end
        m_prev = cs;
    endtask

    task automatic compareAll();
        checkOutput("busy",        32'(busy),          32'(m_busy));
        checkOutput("start_count", start_count,        m_starts);
        checkOutput("done_count",  done_count,         m_dones);
        checkOutput("ready_count", ready_count,        m_readys);
        checkOutput("module_lat",  last_module_latency, m_mod_lat);
        checkOutput("loop_active", 32'(loop_active),   32'(m_active));
        checkOutput("loop_execs",  loop_exec_count,    m_execs);
        checkOutput("iter_count",  iter_count,         m_iters);
        checkOutput("trip_count",  last_trip_count,    m_trip);
        checkOutput("iter_lat",    last_iter_latency,  m_iter_lat);
        checkOutput("frozen",      32'(frozen),        32'(m_frozen));
    endtask

    task automatic applyStimulus(input logic st, input logic rdy, input logic dn,
                                 input logic cont, input logic fin, input logic [STATE_W-1:0] s);
        kif.ap_start    = st;
        kif.ap_ready    = rdy;
        kif.ap_done     = dn;
        kif.ap_continue = cont;
        finish          = fin;
        kif.cur_state   = s;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        modelStep();
        cyc++;
        @(negedge clock);
        compareAll();
    endtask

    task automatic applyReset();
        reset = 1'b0;
        modelReset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic setLoopConfig(input logic [STATE_W-1:0] pre, input logic [STATE_W-1:0] post,
                                 input logic [STATE_W-1:0] quit, input logic [STATE_W-1:0] istart,
                                 input logic [STATE_W-1:0] iend, input logic osl);
        pre_loop_state   = pre;    post_loop_state   = post;
        quit_loop_state  = quit;   iter_start_state  = istart;
        iter_end_state   = iend;   one_state_loop    = osl;
        pre_states_valid = 1;      post_states_valid = 1;
        quit_states_valid = 1;     iter_end_states_valid = 1;
    endtask

    function automatic logic [STATE_W-1:0] randState();
        logic [STATE_W-1:0] v;
        int k;
        v = 4'b0001;
        k = $urandom_range(0, 4);
        return (k == 4) ? '0 : v << k;
    endfunction

    logic [STATE_W-1:0] seq_a [9];
    logic [STATE_W-1:0] seq_b [6];

    initial begin
        seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0001};
        seq_b = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        applyStimulus(0, 0, 0, 0, 0, '0);
        setLoopConfig(4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 0);
        #1;
        modelReset();
        compareAll();
        applyReset();

        // single transaction: start at cycle 0, done at cycle 5
        applyStimulus(1, 0, 0, 1, 0, '0);
        stepCycle();
        checkOutput("tp_busy_c1", 32'(busy), 1);
        applyStimulus(0, 0, 0, 1, 0, '0);
        for (int i = 1; i < 5; i++) stepCycle();
        checkOutput("tp_busy_c5", 32'(busy), 1);
        applyStimulus(0, 0, 1, 1, 0, '0);
        stepCycle();
        applyStimulus(0, 0, 0, 1, 0, '0);
        checkOutput("tp_busy_end", 32'(busy), 0);
        checkOutput("tp_starts", start_count, 1);
        checkOutput("tp_dones", done_count, 1);
        checkOutput("tp_latency", last_module_latency, 6);

        // multi-state loop, two iterations of three cycles
        applyReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 0, 0, seq_a[i]);
            stepCycle();
        end
        checkOutput("tp_loop_execs", loop_exec_count, 1);
        checkOutput("tp_loop_trip", last_trip_count, 2);
        checkOutput("tp_loop_ilat", last_iter_latency, 3);
        checkOutput("tp_loop_active", 32'(loop_active), 0);

        // one-state loop held four cycles
        applyReset();
        setLoopConfig(4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, 0, seq_b[i]);
            stepCycle();
        end
        checkOutput("tp_osl_iters", iter_count, 4);
        checkOutput("tp_osl_trip", last_trip_count, 4);
        checkOutput("tp_osl_ilat", last_iter_latency, 1);

        // back-to-back: start held, done every third cycle
        applyReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 0, (i % 3) == 2, 1, 0, '0);
            stepCycle();
        end
        checkOutput("tp_b2b_starts", start_count, 3);
        checkOutput("tp_b2b_dones", done_count, 3);
        checkOutput("tp_b2b_lat", last_module_latency, 3);

        // finish mid-loop freezes everything
        applyReset();
        setLoopConfig(4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i[0], 1, 0, 1, i == 3, seq_a[i]);
            stepCycle();
        end
        checkOutput("tp_frz_flag", 32'(frozen), 1);
        checkOutput("tp_frz_iters", iter_count, 0);
        checkOutput("tp_frz_active", 32'(loop_active), 1);
        checkOutput("tp_frz_execs", loop_exec_count, 1);
        checkOutput("tp_frz_readys", ready_count, 3);

        // asynchronous reset in the middle of a loop
        applyReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, seq_a[i]);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 4'b1000);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("tp_arst_active", 32'(loop_active), 0);
        checkOutput("tp_arst_execs", loop_exec_count, 0);
        compareAll();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, seq_a[i]);
            stepCycle();
        end
        checkOutput("tp_arst_reentry", loop_exec_count, 1);

        // randomized traffic with random loop configurations
        for (int seg = 0; seg < 12; seg++) begin
            if (m_frozen || $urandom_range(0, 1) == 1) applyReset();
            setLoopConfig(randState(), randState(), randState(),
                          4'b0001 << $urandom_range(0, 3), randState(), $urandom_range(0, 3) == 0);
            pre_states_valid      = $urandom_range(0, 7) != 0;
            post_states_valid     = $urandom_range(0, 7) != 0;
            quit_states_valid     = $urandom_range(0, 7) != 0;
            iter_end_states_valid = $urandom_range(0, 7) != 0;
            for (int i = 0; i < 120; i++) begin
                applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                              $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                              $urandom_range(0, 299) == 0, randState());
                stepCycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
